// File: rtl/alu_mul_sequencer.sv
// Shift-add RV32 MUL sequencer that borrows the execute-stage ALU.
// Returns the low WIDTH bits of OP_A*OP_B after 1..WIDTH RUN cycles.
module alu_mul_sequencer #(
   parameter int          WIDTH   = 32,
   parameter logic [3:0]  ADD_FUN = 4'd0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] OP_A,
   input  logic [WIDTH-1:0] OP_B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             ALU_REQ,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [3:0]       ALU_FUN,
   input  logic [WIDTH-1:0] ALU_OUT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [5:0]       cnt_q, cnt_d;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               acc_d    = '0;
               mcand_d  = OP_A;
               mplier_d = OP_B;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) acc_d = ALU_OUT;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            // Exit as soon as no multiplier bits remain above the current one.
            if (mplier_q[WIDTH-1:1] == '0 || cnt_q == CNT_LAST) begin
               result_d = acc_d;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign BUSY    = (state_q != S_IDLE);
   assign DONE    = (state_q == S_DONE);
   assign ALU_REQ = (state_q == S_RUN);
   assign RESULT  = result_q;
   assign ALU_A   = ALU_REQ ? acc_q   : '0;
   assign ALU_B   = ALU_REQ ? mcand_q : '0;
   assign ALU_FUN = ALU_REQ ? ADD_FUN : 4'd0;

endmodule
